video_pattern_gen: RTL and testbench

//  Parametrised multi-mode test-pattern source for the HDMI path. Sits between video_controller and
//  the TMDS encoder: consumes the controller's O_hor_cnt/O_ver_cnt, drives I_color_data.

---
 rtl/video_pattern_gen.sv | 152 +++++++++++++++
 tb/tb_video_pattern_gen.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/video_pattern_gen.sv
// Multi-mode HDMI test-pattern source: colour bars, checkerboard, grey ramp, solid colour.
// Optional white frame border when PATGEN_BORDER_EN is defined.
module video_pattern_gen #(
    parameter int CNT_W      = 12,
    parameter int H_ACTIVE   = 1280,
    parameter int V_ACTIVE   = 720,
    parameter int NUM_BARS   = 8,
    parameter int CHECK_LOG2 = 5,
    parameter int COLOR_W    = 8
) (
    input  logic                   pxClk,
    input  logic                   I_rst_n,
    input  logic [CNT_W-1:0]       I_hor_cnt,
    input  logic [CNT_W-1:0]       I_ver_cnt,
    input  logic [1:0]             I_mode,
    input  logic [3*COLOR_W-1:0]   I_solid_color,
    output logic [3*COLOR_W-1:0]   O_color_data,
    output logic [1:0]             O_mode_active,
    output logic [7:0]             O_frame_cnt
);

    localparam int PIX_W  = 3 * COLOR_W;
    localparam int BAR_W  = H_ACTIVE / NUM_BARS;
    localparam int SUB_W  = (BAR_W > 1) ? $clog2(BAR_W) : 1;
    localparam int BAR_IW = (NUM_BARS > 1) ? $clog2(NUM_BARS) : 1;

    localparam logic [SUB_W-1:0]  SUB_LAST = SUB_W'(BAR_W - 1);
    localparam logic [BAR_IW-1:0] BAR_LAST = BAR_IW'(NUM_BARS - 1);
    localparam logic [CNT_W-1:0]  H_LIM    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0]  V_LIM    = CNT_W'(V_ACTIVE);

    // Stage-1 registers (aligned with the sampled coordinate)
    logic                 valid_s1_reg;
    logic                 active_s1_reg;
    logic [COLOR_W-1:0]   hor_lo_s1_reg;
    logic                 hor_chk_s1_reg;
    logic                 ver_chk_s1_reg;
    logic [PIX_W-1:0]     solid_s1_reg;
    logic [SUB_W-1:0]     sub_cnt_reg;
    logic [BAR_IW-1:0]    bar_idx_reg;
    logic [2:0]           bar_lut_reg;
`ifdef PATGEN_BORDER_EN
    logic                 border_s1_reg;
`endif

    // Frame-level state and stage-2 colour
    logic [1:0]           mode_reg;
    logic [7:0]           frame_cnt_reg;
    logic [PIX_W-1:0]     color_reg;

    logic [PIX_W-1:0]     color_next;
    logic [PIX_W-1:0]     bar_color;
    logic [PIX_W-1:0]     grey_color;
    logic [2:0]           bar_bgr;
    logic                 frame_start;

    assign frame_start = (I_hor_cnt == '0) && (I_ver_cnt == '0);

    // SMPTE-like bar order, encoded as {B,G,R} channel enables
    always_comb begin
        bar_bgr = 3'b000;
        case (bar_lut_reg)
            3'd0: bar_bgr = 3'b111;
            3'd1: bar_bgr = 3'b011;
            3'd2: bar_bgr = 3'b110;
            3'd3: bar_bgr = 3'b010;
            3'd4: bar_bgr = 3'b101;
            3'd5: bar_bgr = 3'b001;
            3'd6: bar_bgr = 3'b100;
            default: bar_bgr = 3'b000;
        endcase
    end

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_chan
            assign bar_color[gi*COLOR_W +: COLOR_W]  = {COLOR_W{bar_bgr[gi]}};
            assign grey_color[gi*COLOR_W +: COLOR_W] = hor_lo_s1_reg;
        end
    endgenerate

    always_comb begin
        color_next = '0;
        if (valid_s1_reg && active_s1_reg) begin
`ifdef PATGEN_BORDER_EN
            if (border_s1_reg)
                color_next = '1;
            else
`endif
            case (mode_reg)
                2'd0:    color_next = bar_color;
                2'd1:    color_next = (hor_chk_s1_reg ^ ver_chk_s1_reg) ? '0 : '1;
                2'd2:    color_next = grey_color;
                default: color_next = solid_s1_reg;
            endcase
        end
    end

    always_ff @(posedge pxClk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            valid_s1_reg   <= 1'b0;
            active_s1_reg  <= 1'b0;
            hor_lo_s1_reg  <= '0;
            hor_chk_s1_reg <= 1'b0;
            ver_chk_s1_reg <= 1'b0;
            solid_s1_reg   <= '0;
            sub_cnt_reg    <= '0;
            bar_idx_reg    <= '0;
            bar_lut_reg    <= '0;
`ifdef PATGEN_BORDER_EN
            border_s1_reg  <= 1'b0;
`endif
            mode_reg       <= 2'd0;
            frame_cnt_reg  <= 8'd0;
            color_reg      <= '0;
        end else begin
            valid_s1_reg   <= 1'b1;
            active_s1_reg  <= (I_hor_cnt < H_LIM) && (I_ver_cnt < V_LIM);
            hor_lo_s1_reg  <= I_hor_cnt[COLOR_W-1:0];
            hor_chk_s1_reg <= I_hor_cnt[CHECK_LOG2];
            ver_chk_s1_reg <= I_ver_cnt[CHECK_LOG2];
            solid_s1_reg   <= I_solid_color;
`ifdef PATGEN_BORDER_EN
            border_s1_reg  <= (I_hor_cnt == '0) || (I_hor_cnt == H_LIM - 1'b1) ||
                              (I_ver_cnt == '0) || (I_ver_cnt == V_LIM - 1'b1);
`endif
            // Divider-free bar tracking; hor==0 re-syncs after any counter jump
            if (I_hor_cnt == '0) begin
                sub_cnt_reg <= '0;
                bar_idx_reg <= '0;
                bar_lut_reg <= '0;
            end else if (sub_cnt_reg == SUB_LAST) begin
                sub_cnt_reg <= '0;
                if (bar_idx_reg != BAR_LAST) begin
                    bar_idx_reg <= bar_idx_reg + BAR_IW'(1);
                    bar_lut_reg <= bar_lut_reg + 3'd1;
                end
            end else begin
                sub_cnt_reg <= sub_cnt_reg + SUB_W'(1);
            end
            if (frame_start) begin
                mode_reg      <= I_mode;
                frame_cnt_reg <= frame_cnt_reg + 8'd1;
            end
            color_reg <= color_next;
        end
    end

    assign O_color_data  = color_reg;
    assign O_mode_active = mode_reg;
    assign O_frame_cnt   = frame_cnt_reg;

endmodule

// File: tb/tb_video_pattern_gen.sv
// Scoreboard bench for video_pattern_gen: expectations are queued at drive time and
// compared when the pixel leaves the two-stage pipeline.
module tb_video_pattern_gen;

    localparam int CNT_W    = 12;
    localparam int H_ACTIVE = 1280;
    localparam int V_ACTIVE = 720;
    localparam int NUM_BARS = 8;
    localparam int BAR_W    = H_ACTIVE / NUM_BARS;

    logic        pxClk = 1'b0;
    logic        I_rst_n;
    logic [11:0] I_hor_cnt;
    logic [11:0] I_ver_cnt;
    logic [1:0]  I_mode;
    logic [23:0] I_solid_color;
    logic [23:0] O_color_data;
    logic [1:0]  O_mode_active;
    logic [7:0]  O_frame_cnt;

    always #5 pxClk = ~pxClk;

    video_pattern_gen dut (
        .pxClk         (pxClk),
        .I_rst_n       (I_rst_n),
        .I_hor_cnt     (I_hor_cnt),
        .I_ver_cnt     (I_ver_cnt),
        .I_mode        (I_mode),
        .I_solid_color (I_solid_color),
        .O_color_data  (O_color_data),
        .O_mode_active (O_mode_active),
        .O_frame_cnt   (O_frame_cnt)
    );

    typedef struct {
        logic [23:0] exp;
        int          chk;
        int          h;
        int          v;
    } sb_t;

    sb_t q[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    int  exp_mode = 0;
    int  exp_frames = 0;

    function automatic logic [23:0] model(int h, int v, int mode, logic [23:0] solid);
        int bar;
        logic [7:0] g;
        bar = h / BAR_W;
        if (bar > NUM_BARS - 1) bar = NUM_BARS - 1;
        if (!(h < H_ACTIVE && v < V_ACTIVE)) return 24'h000000;
`ifdef PATGEN_BORDER_EN
        if (h == 0 || h == H_ACTIVE - 1 || v == 0 || v == V_ACTIVE - 1) return 24'hFFFFFF;
`endif
        case (mode)
            0: case (bar % 8)
                   0: return 24'hFFFFFF;
                   1: return 24'h00FFFF;
                   2: return 24'hFFFF00;
                   3: return 24'h00FF00;
                   4: return 24'hFF00FF;
                   5: return 24'h0000FF;
                   6: return 24'hFF0000;
                   default: return 24'h000000;
               endcase
            1: return ((((h >> 5) & 1) ^ ((v >> 5) & 1)) != 0) ? 24'h000000 : 24'hFFFFFF;
            2: begin
                   g = 8'(h & 255);
                   return {g, g, g};
               end
            default: return solid;
        endcase
    endfunction

    // One pixel per call: retire the oldest in-flight pixel, then drive a new one.
    task automatic step(input int h, input int v, input int mode, input logic [23:0] solid,
                        input int chk);
        sb_t e;
        sb_t n;
        @(negedge pxClk);
        if (q.size() == 2) begin
            e = q.pop_front();
            if (e.chk != 0) begin
                n_cmp++;
                if (O_color_data !== e.exp) begin
                    n_bad++;
                    $display("FAIL pixel(%0d,%0d) got %06h expected %06h", e.h, e.v, O_color_data, e.exp);
                end else if (e.chk == 2) begin
                    $display("pixel(%0d,%0d) color %06h ok", e.h, e.v, O_color_data);
                end
            end
        end
        I_hor_cnt     = CNT_W'(h);
        I_ver_cnt     = CNT_W'(v);
        I_mode        = 2'(mode);
        I_solid_color = solid;
        if (h == 0 && v == 0) begin
            exp_mode   = mode;
            exp_frames = (exp_frames + 1) % 256;
        end
        n.exp = model(h, v, exp_mode, solid);
        n.chk = chk;
        n.h   = h;
        n.v   = v;
        q.push_back(n);
    endtask

    task automatic flush(input int mode);
        step(1300, 800, mode, 24'h0, 0);
        step(1300, 800, mode, 24'h0, 0);
    endtask

    task automatic check_status(input string tag);
        n_cmp++;
        if (O_frame_cnt !== 8'(exp_frames)) begin
            n_bad++;
            $display("FAIL %s frame_cnt got %0d expected %0d", tag, O_frame_cnt, exp_frames);
        end
        n_cmp++;
        if (O_mode_active !== 2'(exp_mode)) begin
            n_bad++;
            $display("FAIL %s mode_active got %0d expected %0d", tag, O_mode_active, exp_mode);
        end
        $display("%s frame_cnt=%0d mode_active=%0d", tag, O_frame_cnt, O_mode_active);
    endtask

    task automatic check_zero(input string tag);
        n_cmp++;
        if (O_color_data !== 24'h0) begin
            n_bad++;
            $display("FAIL %s color got %06h expected 000000", tag, O_color_data);
        end
        exp_mode   = 0;
        exp_frames = 0;
        check_status(tag);
    endtask

    task automatic test_reset();
        I_rst_n = 1'b1;
        #2 I_rst_n = 1'b0;
        #1 check_zero("reset_init");
        repeat (2) @(negedge pxClk);
        I_rst_n = 1'b1;
        q.delete();
    endtask

    task automatic test_bars();
        step(0, 0, 0, 24'h0, 1);
        for (int h = 1; h < H_ACTIVE; h++) begin
            step(h, 0, 0, 24'h0, (h == 159 || h == 160 || h == 1279) ? 2 : 1);
            if (h == 1) check_status("bars_fs");
        end
        flush(0);
    endtask

    task automatic test_checker();
        step(0, 0, 1, 24'h0, 1);
        step(31, 0, 1, 24'h0, 2);
        step(32, 0, 1, 24'h0, 2);
        step(0, 32, 1, 24'h0, 2);
        step(32, 32, 1, 24'h0, 2);
        step(100, 70, 1, 24'h0, 2);
        flush(1);
    endtask

    task automatic test_mode_switch();
        step(0, 0, 0, 24'h0, 1);
        for (int h = 0; h < 400; h++) begin
            step(h, 300, 2, 24'h0, (h == 200 || h == 399) ? 2 : 1);
            if (h == 10) check_status("switch_midframe");
        end
        step(0, 0, 2, 24'h0, 1);
        for (int h = 1; h <= 5; h++) begin
            step(h, 0, 2, 24'h0, (h == 5) ? 2 : 1);
            if (h == 1) check_status("switch_fs");
        end
        step(200, 10, 2, 24'h0, 2);
        flush(2);
    endtask

    task automatic test_solid();
        step(0, 0, 3, 24'h123456, 1);
        step(1280, 5, 3, 24'h123456, 2);
        step(5, 720, 3, 24'h123456, 2);
        step(100, 100, 3, 24'h123456, 2);
        step(101, 100, 3, 24'hABCDEF, 2);
        step(1279, 719, 3, 24'h123456, 2);
        flush(3);
    endtask

    task automatic test_border();
        step(0, 0, 3, 24'h0000FF, 1);
        step(0, 10, 3, 24'h0000FF, 2);
        step(1279, 10, 3, 24'h0000FF, 2);
        step(10, 719, 3, 24'h0000FF, 2);
        step(1, 1, 3, 24'h0000FF, 2);
        flush(3);
    endtask

    task automatic test_frame_wrap();
        for (int i = 0; i < 300 && exp_frames != 255; i++)
            step(0, 0, 2, 24'h0, 0);
        step(1, 0, 2, 24'h0, 1);
        check_status("frame_255");
        step(0, 0, 2, 24'h0, 1);
        step(1, 0, 2, 24'h0, 1);
        check_status("frame_wrap");
        flush(2);
    endtask

    task automatic test_reset_mid();
        step(0, 0, 2, 24'h0, 1);
        for (int h = 1; h <= 20; h++) step(h, 1, 2, 24'h0, 1);
        #2 I_rst_n = 1'b0;
        #1 check_zero("reset_mid");
        q.delete();
        repeat (2) @(negedge pxClk);
        I_rst_n = 1'b1;
        for (int h = 0; h <= 200; h++) begin
            step(h, 3, 2, 24'h0, (h == 160) ? 2 : 1);
            if (h == 100) check_status("after_reset");
        end
        flush(2);
    endtask

    initial begin
        I_rst_n       = 1'b1;
        I_hor_cnt     = 12'd1300;
        I_ver_cnt     = 12'd800;
        I_mode        = 2'd0;
        I_solid_color = 24'h0;
        test_reset();
        test_bars();
        test_checker();
        test_mode_switch();
        test_solid();
        test_border();
        test_frame_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
